// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch front end
// Contents:
//   XLEN          datapath width
//   BUBBLE_INST   value presented on the F outputs when no instruction is valid
//   fetch_entry_t one prefetch FIFO entry {inst, pc}
//   pc_align()    clears the byte offset of an address
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] BUBBLE_INST = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO of fetch_entry_t
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        empties the FIFO; wins over push and pop
//   push, push_data  write an entry
//   pop          discard the head entry (ignored when empty)
//   head         entry at the read pointer
//   count        current occupancy (0..DEPTH)
//   empty        count == 0
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !clear;
        // A push into a full FIFO is only accepted when a pop frees a slot.
        do_push  = push && !clear && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end feeding the IF/ID register
// Issues sequential word requests, buffers in-order responses in a prefetch
// FIFO and presents the head as INST_F / PC_F / PC4_F.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold the current F outputs
//   redirect, redirect_pc  restart fetch at the word-aligned target
//   imem_req_*          request channel (valid/ready, byte address)
//   imem_rsp_*          in-order response channel, no backpressure
//   INST_F, PC_F, PC4_F, valid_F  FIFO head, zero when empty
//   perf_fetched/dropped/bubble   counters, live only with FETCH_PERF_EN
// Optional feature macro: FETCH_PERF_EN (undefined: counters tied to 0).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] INST_F,
    output logic [XLEN-1:0] PC_F,
    output logic [XLEN-1:0] PC4_F,
    output logic            valid_F,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_dropped,
    output logic [XLEN-1:0] perf_bubble
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] DEPTH_U   = 32'(FIFO_DEPTH);

    logic            started_q, started_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_push, fifo_pop;
    logic            req_fire, rsp_drop;
    fetch_entry_t    fifo_head, fifo_wdata;

    always_comb begin
        // started_q keeps the request channel quiet during and right after reset.
        // Counting outstanding requests against free FIFO slots reserves a slot
        // for every response, so the response path never needs backpressure.
        imem_req_valid = started_q && !redirect
                         && (32'(outstanding_q) < MAX_OUT_U)
                         && ((32'(fifo_count) + 32'(outstanding_q)) < DEPTH_U);
        req_fire  = imem_req_valid && imem_req_ready;
        // A response in the redirect cycle belongs to the abandoned stream.
        rsp_drop  = imem_rsp_valid && (redirect || (drop_cnt_q != '0));
        fifo_push = imem_rsp_valid && !rsp_drop;
        fifo_pop  = valid_F && !stall && !redirect;

        started_d     = 1'b1;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect) begin
            req_pc_d   = pc_align(redirect_pc);
            rsp_pc_d   = pc_align(redirect_pc);
            // No request is issued this cycle, so every request still in
            // flight after this edge was issued for the old stream.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                req_pc_d = req_pc_q + 32'd4;
            end
            if (fifo_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            started_q     <= started_d;
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign imem_req_addr = req_pc_q;
    assign fifo_wdata    = '{inst: imem_rsp_data, pc: rsp_pc_q};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Empty FIFO shows the same all-zero value the IF/ID register uses on flush.
    assign valid_F = !fifo_empty;
    assign INST_F  = fifo_empty ? BUBBLE_INST : fifo_head.inst;
    assign PC_F    = fifo_empty ? '0 : fifo_head.pc;
    assign PC4_F   = fifo_empty ? '0 : (fifo_head.pc + 32'd4);

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
    logic [XLEN-1:0] perf_dropped_q, perf_dropped_d;
    logic [XLEN-1:0] perf_bubble_q,  perf_bubble_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + XLEN'(fifo_pop);
        perf_dropped_d = perf_dropped_q + XLEN'(rsp_drop);
        perf_bubble_d  = perf_bubble_q  + XLEN'(!valid_F && !stall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
            perf_bubble_q  <= perf_bubble_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
    assign perf_bubble  = perf_bubble_q;
`else
    assign perf_fetched = '0;
    assign perf_dropped = '0;
    assign perf_bubble  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic        stall          = 1'b0;
    logic        redirect       = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] INST_F, PC_F, PC4_F;
    logic        valid_F;
    logic [31:0] perf_fetched, perf_dropped, perf_bubble;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] addr;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int          cyc      = 0;
    int          lat      = 1;
    int          hs_count = 0;
    int          pops     = 0;
    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] first_addr = 32'hFFFF_FFFF;

    fetch_unit #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .INST_F         (INST_F),
        .PC_F           (PC_F),
        .PC4_F          (PC4_F),
        .valid_F        (valid_F),
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped),
        .perf_bubble    (perf_bubble)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_pops(input int target, input int budget);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_pops_in_budget", 32'(pops >= target), 32'd1);
        tick(1);
    endtask

    // Memory response driver: presents each accepted request lat cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            if (!rst_n) begin
                pend_q.delete();
            end else if (pend_q.size() > 0 && pend_q[0].due == 32'(cyc)) begin
                imem_rsp_data  = mem_word(pend_q[0].addr);
                imem_rsp_valid = 1'b1;
                void'(pend_q.pop_front());
            end
        end
    end

    // Request capture and scoreboard monitor.
    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hs_count   = 0;
                first_addr = 32'hFFFF_FFFF;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    pend_q.push_back('{due: 32'(cyc + lat), addr: imem_req_addr});
                    hs_count++;
                    if (hs_count == 1) first_addr = imem_req_addr;
                end
                if (valid_F && !stall && !redirect) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: got PC_F %h, want no instruction", PC_F);
                    end else begin
                        pc = exp_q.pop_front();
                        check("PC_F", PC_F, pc);
                        check("INST_F", INST_F, mem_word(pc));
                        check("PC4_F", PC4_F, pc + 32'd4);
                    end
                    pops++;
                end else if (!valid_F) begin
                    check("bubble_outputs_zero", PC_F | INST_F | PC4_F, 32'h0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          p0;
        logic [31:0] held_addr;
        logic [31:0] b0;
        logic [31:0] f0;

        // Reset state
        imem_req_ready = 1'b1;
        tick(2);
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_valid_F", 32'(valid_F), 32'd0);
        check("reset_outputs", PC_F | INST_F | PC4_F, 32'h0);
        check("reset_perf", perf_fetched | perf_dropped | perf_bubble, 32'h0);

        // Steady sequential stream, 1-cycle memory
        push_seq(RESET_PC, 200);
        rst_n = 1'b1;
        wait_pops(3, 30);
        check("first_req_addr", first_addr, RESET_PC);
        p0 = pops;
        f0 = perf_fetched;
        tick(10);
        check("steady_one_per_cycle", 32'(pops - p0), 32'd10);
`ifdef FETCH_PERF_EN
        check("perf_fetched_window", perf_fetched - f0, 32'd10);
`endif

        // Memory not ready for 5 cycles
        imem_req_ready = 1'b0;
        b0 = perf_bubble;
        held_addr = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("held_req_valid", 32'(imem_req_valid), 32'd1);
            check("held_req_addr", imem_req_addr, held_addr);
        end
        check("drained_valid_F", 32'(valid_F), 32'd0);
        tick(1);
`ifdef FETCH_PERF_EN
        check("perf_bubble_not_ready", perf_bubble - b0, 32'd3);
`endif
        imem_req_ready = 1'b1;
        tick(12);

        // Stall 6 cycles: FIFO fills, requests stop, head holds
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_head_pc", PC_F, exp_q[0]);
        end
        check("stall_full_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_valid_F", 32'(valid_F), 32'd1);
        tick(1);
        stall = 1'b0;
        wait_pops(pops + 12, 40);

        // Asynchronous reset with requests in flight
        lat = 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pend_q.size() < 2 && n < 50);
        check("two_in_flight_found", 32'(n < 50), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid_F", 32'(valid_F), 32'd0);
        check("async_reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_reset_outputs", PC_F | INST_F | PC4_F, 32'h0);
        exp_q.delete();
        tick(2);
        lat = 1;
        push_seq(RESET_PC, 100);
        rst_n = 1'b1;
        wait_pops(pops + 6, 30);
        check("restart_first_req_addr", first_addr, RESET_PC);

        // Redirect to 0x103 with two requests outstanding and no response
        rst_n = 1'b0;
        exp_q.delete();
        tick(2);
        lat = 3;
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req_valid && imem_req_addr == 32'h4) && n < 20);
        check("second_req_seen", 32'(n < 20), 32'd1);
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        exp_q.delete();
        push_seq(32'h0000_0100, 100);
        #1;
        check("redirect_cycle_req_valid", 32'(imem_req_valid), 32'd0);
        tick(1);
        redirect = 1'b0;
        wait_pops(pops + 3, 40);
`ifdef FETCH_PERF_EN
        check("perf_dropped_redirect", perf_dropped, 32'd2);
`endif

        // Redirect together with stall and a response in the same cycle
        tick(10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pend_q.size() > 0 && pend_q[0].due == 32'(cyc + 1)) && n < 40);
        check("rsp_slot_found", 32'(n < 40), 32'd1);
        tick(1);
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_q.delete();
        push_seq(32'h0000_0200, 100);
        #1;
        check("redirect_rsp_present", 32'(imem_rsp_valid), 32'd1);
        tick(1);
        redirect = 1'b0;
        stall    = 1'b0;
        #1;
        check("post_redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_redirect_req_addr", imem_req_addr, 32'h0000_0200);
        check("post_redirect_fifo_clear", 32'(valid_F), 32'd0);
        wait_pops(pops + 4, 60);

`ifndef FETCH_PERF_EN
        check("perf_tied_zero", perf_fetched | perf_dropped | perf_bubble, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
